aucohl_sar_seq: RTL and testbench

//  Conversion sequencer and averager placed directly downstream of the SAR controller.
//  - Issues soc pulses and captures data on eoc.
//  - Accumulates 2^navg_log2 samples and presents the truncated mean on a valid/ready port.
//  - The ready input connects to a FIFO as ~full; avg_valid&avg_ready drives the FIFO wr.
//  - Supports single-shot and periodic continuous operation.

---
 rtl/aucohl_sar_seq.sv | 158 +++++++++++++++
 tb/tb_aucohl_sar_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aucohl_sar_seq.sv
// Conversion sequencer and averager downstream of the SAR controller: issues soc, accumulates
// 2^n samples and offers the truncated mean on a valid/ready port. Optional watchdog: AUCOHL_SAR_SEQ_TIMEOUT_EN.
module aucohl_sar_seq #(
  parameter int SIZE   = 8,
  parameter int MAXLOG = 4,
  parameter int PW     = 16,
  parameter int TW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic            cont,
  input  logic [PW-1:0]   period,
  input  logic [2:0]      navg_log2,
  output logic            soc,
  input  logic            eoc,
  input  logic [SIZE-1:0] data,
  output logic [SIZE-1:0] avg_data,
  output logic            avg_valid,
  input  logic            avg_ready,
  output logic            busy,
  output logic            err
);

  localparam int AW = SIZE + MAXLOG;
  localparam int CW = MAXLOG + 1;
  localparam int NW = $clog2(MAXLOG + 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, CONV, OUT} state_t;

  if (SIZE < 1 || MAXLOG < 1 || PW < 1 || TW < 2) begin : g_bad_param
    $error("aucohl_sar_seq: illegal parameter combination");
  end

  state_t          state;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   n;
  logic [PW-1:0]   wcnt;
  logic [AW-1:0]   sum;
  logic            last;
  logic [NW-1:0]   n_clamped;

  assign sum  = acc + AW'(data);
  assign last = (cnt == ((CW'(1) << n) - CW'(1)));
  assign busy = (state != IDLE);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    n_clamped = NW'(MAXLOG);
    if (int'(navg_log2) <= MAXLOG) n_clamped = NW'(navg_log2);
  end

`ifdef AUCOHL_SAR_SEQ_TIMEOUT_EN
  logic [TW-1:0] wd;
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      n         <= '0;
      wcnt      <= '0;
      soc       <= 1'b0;
      avg_valid <= 1'b0;
      avg_data  <= '0;
`ifdef AUCOHL_SAR_SEQ_TIMEOUT_EN
      wd        <= '0;
      err       <= 1'b0;
`endif
    end else if (!en) begin
      // A pending result is dropped; the watchdog error flag survives.
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      soc       <= 1'b0;
      avg_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n     <= n_clamped;
            acc   <= '0;
            cnt   <= '0;
            soc   <= 1'b1;
            state <= START;
          end
        end
        START: begin
          soc   <= 1'b0;
          state <= CONV;
`ifdef AUCOHL_SAR_SEQ_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        CONV: begin
          if (eoc) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            if (last) begin
              avg_data  <= SIZE'(sum >> n);
              avg_valid <= 1'b1;
              state     <= OUT;
            end else if (period == '0) begin
              soc   <= 1'b1;
              state <= START;
            end else begin
              wcnt  <= period;
              state <= WAIT;
            end
          end
`ifdef AUCOHL_SAR_SEQ_TIMEOUT_EN
          else if (wd == {{(TW-1){1'b1}}, 1'b0}) begin
            err   <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            wd <= wd + TW'(1);
          end
`endif
        end
        WAIT: begin
          if (wcnt <= PW'(1)) begin
            soc   <= 1'b1;
            state <= START;
          end else begin
            wcnt <= wcnt - PW'(1);
          end
        end
        OUT: begin
          // No soc leaves this state until the result is taken, so no sample is lost.
          if (avg_ready) begin
            avg_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            if (!cont) begin
              state <= IDLE;
            end else if (period == '0) begin
              soc   <= 1'b1;
              state <= START;
            end else begin
              wcnt  <= period;
              state <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aucohl_sar_seq.sv
// Self-checking bench for aucohl_sar_seq: a SAR stub answers soc with eoc after a random
// latency; averages and soc timing are predicted from sums and period counts.
module tb_aucohl_sar_seq;
  localparam int SIZE = 8, MAXLOG = 4, PW = 16, TW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            start = 1'b0;
  logic            cont = 1'b0;
  logic [PW-1:0]   period = '0;
  logic [2:0]      navg_log2 = '0;
  logic            soc;
  logic            eoc = 1'b0;
  logic [SIZE-1:0] data = '0;
  logic [SIZE-1:0] avg_data;
  logic            avg_valid;
  logic            avg_ready = 1'b0;
  logic            busy;
  logic            err;

  int vectors = 0;
  int miscompares = 0;

  aucohl_sar_seq #(.SIZE(SIZE), .MAXLOG(MAXLOG), .PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .period(period),
    .navg_log2(navg_log2), .soc(soc), .eoc(eoc), .data(data), .avg_data(avg_data),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Outputs are read and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SAR stub: waits for soc (w = cycles waited, -1 on timeout), answers after lat cycles.
  task automatic serve(input int lat, input logic [7:0] d, output int w, output bit one_cycle);
    w = 0;
    one_cycle = 1'b0;
    while (soc !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      w = -1;
      return;
    end
    tick();
    one_cycle = (soc === 1'b0);
    for (int i = 1; i < lat; i++) tick();
    eoc = 1'b1;
    data = d;
    tick();
    eoc = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (soc !== 1'b0) begin miscompares++; $display("FAIL reset_soc got %b want 0", soc); end
    vectors++; if (avg_valid !== 1'b0) begin miscompares++; $display("FAIL reset_avg_valid got %b want 0", avg_valid); end
    vectors++; if (avg_data !== 8'h00) begin miscompares++; $display("FAIL reset_avg_data got %h want 00", avg_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    // Reset in the middle of a conversion.
    navg_log2 = 3'd0;
    kick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || soc !== 1'b0) begin miscompares++; $display("FAIL midop_reset busy/soc got %b%b want 00", busy, soc); end
  endtask

  task automatic test_single();
    int extra_soc = 0;
    cont = 1'b0;
    navg_log2 = 3'd0;
    period = 16'd5;
    avg_ready = 1'b0;
    kick();
    vectors++; if (soc !== 1'b1) begin miscompares++; $display("FAIL single_soc_t1 got %b want 1", soc); end
    tick();
    for (int i = 0; i < 10; i++) begin
      if (soc !== 1'b0) extra_soc++;
      tick();
    end
    eoc = 1'b1;
    data = 8'hA5;
    tick();
    eoc = 1'b0;
    vectors++; if (extra_soc != 0) begin miscompares++; $display("FAIL single_soc_width extra cycles got %0d want 0", extra_soc); end
    vectors++; if (avg_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_t13 got %b want 1", avg_valid); end
    vectors++; if (avg_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", avg_data); end
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    vectors++; if (avg_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle valid/busy got %b%b want 00", avg_valid, busy); end
  endtask

  task automatic test_period_avg();
    logic [7:0] samples [4] = '{8'd10, 8'd20, 8'd30, 8'd41};
    int w, bad_gap = 0, bad_width = 0, early_valid = 0, sum = 0;
    bit oc;
    cont = 1'b0;
    navg_log2 = 3'd2;
    period = 16'd3;
    avg_ready = 1'b0;
    kick();
    for (int k = 0; k < 4; k++) begin
      serve(int'($urandom_range(5, 1)), samples[k], w, oc);
      sum += int'(samples[k]);
      if (w != (k == 0 ? 0 : 3)) bad_gap++;
      if (!oc) bad_width++;
      if (k < 3 && avg_valid !== 1'b0) early_valid++;
    end
    vectors++; if (bad_gap != 0) begin miscompares++; $display("FAIL period_soc_gap wrong gaps got %0d want 0", bad_gap); end
    vectors++; if (bad_width != 0) begin miscompares++; $display("FAIL period_soc_width wrong pulses got %0d want 0", bad_width); end
    vectors++; if (early_valid != 0) begin miscompares++; $display("FAIL period_early_valid got %0d want 0", early_valid); end
    vectors++; if (avg_valid !== 1'b1 || avg_data !== 8'(sum >> 2)) begin
      miscompares++; $display("FAIL period_avg valid/data got %b/%h want 1/%h", avg_valid, avg_data, 8'(sum >> 2)); end
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL period_idle busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int w, sum = 0, held_bad = 0;
    bit oc;
    logic [7:0] d;
    logic [7:0] exp_avg;
    cont = 1'b1;
    navg_log2 = 3'd1;
    period = 16'd2;
    avg_ready = 1'b0;
    kick();
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      sum += int'(d);
      serve(int'($urandom_range(4, 1)), d, w, oc);
    end
    exp_avg = 8'(sum >> 1);
    vectors++; if (avg_valid !== 1'b1 || avg_data !== exp_avg) begin
      miscompares++; $display("FAIL bp_avg valid/data got %b/%h want 1/%h", avg_valid, avg_data, exp_avg); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avg_valid !== 1'b1 || avg_data !== exp_avg || soc !== 1'b0) held_bad++;
    end
    vectors++; if (held_bad != 0) begin miscompares++; $display("FAIL bp_hold bad cycles got %0d want 0", held_bad); end
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    sum = 0;
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      sum += int'(d);
      serve(int'($urandom_range(4, 1)), d, w, oc);
      if (k == 0) begin
        vectors++; if (w != 2) begin miscompares++; $display("FAIL bp_resume_gap got %0d want 2", w); end
      end
    end
    exp_avg = 8'(sum >> 1);
    vectors++; if (avg_valid !== 1'b1 || avg_data !== exp_avg) begin
      miscompares++; $display("FAIL bp_avg2 valid/data got %b/%h want 1/%h", avg_valid, avg_data, exp_avg); end
    cont = 1'b0;
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_stop busy got %b want 0", busy); end
  endtask

  task automatic test_clamp();
    int w, bad_gap = 0, early_valid = 0;
    bit oc;
    cont = 1'b0;
    navg_log2 = 3'd7;
    period = 16'd0;
    kick();
    for (int k = 0; k < 16; k++) begin
      serve(int'($urandom_range(3, 1)), 8'hFF, w, oc);
      if (w != 0) bad_gap++;
      if (k < 15 && avg_valid !== 1'b0) early_valid++;
    end
    vectors++; if (bad_gap != 0 || early_valid != 0) begin
      miscompares++; $display("FAIL clamp_seq gaps/early got %0d/%0d want 0/0", bad_gap, early_valid); end
    vectors++; if (avg_valid !== 1'b1 || avg_data !== 8'hFF) begin
      miscompares++; $display("FAIL clamp_avg valid/data got %b/%h want 1/ff", avg_valid, avg_data); end
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
  endtask

  task automatic test_en_drop();
    int bad = 0;
    cont = 1'b0;
    navg_log2 = 3'd0;
    period = 16'd1;
    kick();
    tick();
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    vectors++; if (busy !== 1'b0 || avg_valid !== 1'b0) begin
      miscompares++; $display("FAIL endrop_idle busy/valid got %b%b want 00", busy, avg_valid); end
    eoc = 1'b1;
    data = 8'h3C;
    tick();
    eoc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || avg_valid !== 1'b0 || soc !== 1'b0) bad++;
      tick();
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL endrop_stray_eoc bad cycles got %0d want 0", bad); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nreq, nc, per, w, sum = 0, bad_gap = 0, held_bad = 0;
      bit oc;
      logic [7:0] d;
      logic [7:0] exp_avg;
      nreq = int'($urandom_range(7, 0));
      nc = (nreq > MAXLOG) ? MAXLOG : nreq;
      per = int'($urandom_range(4, 0));
      navg_log2 = 3'(nreq);
      period = 16'(per);
      cont = 1'b0;
      avg_ready = 1'b0;
      kick();
      for (int k = 0; k < (1 << nc); k++) begin
        d = 8'($urandom);
        sum += int'(d);
        serve(int'($urandom_range(4, 1)), d, w, oc);
        if (w != (k == 0 ? 0 : per) || !oc) bad_gap++;
      end
      exp_avg = 8'(sum >> nc);
      vectors++; if (bad_gap != 0) begin miscompares++; $display("FAIL rand%0d_soc_timing bad samples got %0d want 0", it, bad_gap); end
      vectors++; if (avg_valid !== 1'b1 || avg_data !== exp_avg) begin
        miscompares++; $display("FAIL rand%0d_avg n=%0d valid/data got %b/%h want 1/%h", it, nreq, avg_valid, avg_data, exp_avg); end
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) begin
        tick();
        if (avg_valid !== 1'b1 || avg_data !== exp_avg) held_bad++;
      end
      avg_ready = 1'b1;
      tick();
      avg_ready = 1'b0;
      vectors++; if (held_bad != 0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL rand%0d_handshake held_bad/busy got %0d/%b want 0/0", it, held_bad, busy); end
    end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_tied got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_period_avg();
    test_backpressure();
    test_clamp();
    test_en_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
